// File: rtl/gcd_unit_multi_engine_pkg.sv
// Shared types and helpers for the multi-engine GCD unit: engine state encoding,
// pointer sizing and a request-pack helper usable by RTL and bench alike.
package gcd_unit_multi_engine_pkg;

  typedef enum logic [1:0] {
    ENG_IDLE = 2'd0,
    ENG_CALC = 2'd1,
    ENG_DONE = 2'd2
  } eng_state_e;

  // Widest operand the pack helper handles; callers pass their real width.
  localparam int unsigned GCD_MAX_WIDTH = 64;

  typedef logic [GCD_MAX_WIDTH-1:0]   gcd_word_t;
  typedef logic [2*GCD_MAX_WIDTH-1:0] gcd_imsg_t;

  // Packs {a,b} for an operand width of 'width'; slice the low 2*width bits.
  function automatic gcd_imsg_t mk_imsg(input int unsigned width,
                                        input gcd_word_t   a,
                                        input gcd_word_t   b);
    gcd_imsg_t mask;
    gcd_imsg_t hi;
    mask = (gcd_imsg_t'(1) << width) - gcd_imsg_t'(1);
    hi   = (gcd_imsg_t'(a) & mask) << width;
    return hi | (gcd_imsg_t'(b) & mask);
  endfunction

  // A single engine still needs a 1-bit pointer.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gcd_unit_multi_engine_engine.sv
// One subtractive-Euclid engine: IDLE -> CALC (one swap/subtract per cycle) -> DONE,
// holding its result until the collector unloads it.
module gcd_unit_multi_engine_engine
  import gcd_unit_multi_engine_pkg::*;
#(
  parameter int p_width = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [p_width-1:0] a_i,
  input  logic [p_width-1:0] b_i,
  input  logic               unload_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [p_width-1:0] result_o,
  output eng_state_e         state_o
);

  eng_state_e         state_q, state_d;
  logic [p_width-1:0] a_q, a_d;
  logic [p_width-1:0] b_q, b_d;
  logic               a_lt_b;
  logic               b_zero;

  assign a_lt_b = (a_q < b_q);
  assign b_zero = (b_q == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ENG_IDLE;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  // Swap is tested before subtract, so a-b never underflows.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      ENG_IDLE: begin
        if (load_i) begin
          state_d = ENG_CALC;
          a_d     = a_i;
          b_d     = b_i;
        end
      end
      ENG_CALC: begin
        if (a_lt_b) begin
          a_d = b_q;
          b_d = a_q;
        end else if (!b_zero) begin
          a_d = a_q - b_q;
        end else begin
          state_d = ENG_DONE;
        end
      end
      ENG_DONE: begin
        if (unload_i) state_d = ENG_IDLE;
      end
      default: state_d = ENG_IDLE;
    endcase
  end

  always_comb begin
    busy_o   = (state_q != ENG_IDLE);
    done_o   = (state_q == ENG_DONE);
    result_o = (state_q == ENG_DONE) ? a_q : '0;
    state_o  = state_q;
  end

endmodule

// File: rtl/gcd_unit_multi_engine.sv
// Multi-engine GCD unit: requests go round-robin to engines via dptr, responses are
// collected round-robin via cptr, so results leave in request order with no reorder buffer.
module gcd_unit_multi_engine
  import gcd_unit_multi_engine_pkg::*;
#(
  parameter int p_width       = 16,
  parameter int p_num_engines = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  // Streams: a beat transfers on a posedge where val && rdy; a producer holding val
  // keeps msg stable until it transfers, and rdy never depends on val.
  input  logic                                  istream_val_i,
  output logic                                  istream_rdy_o,
  input  logic [2*p_width-1:0]                  istream_msg_i,
  output logic                                  ostream_val_o,
  input  logic                                  ostream_rdy_i,
  output logic [p_width-1:0]                    ostream_msg_o,
  output logic [2*p_num_engines-1:0]            dbg_eng_state_o,
  output logic [ptr_width(p_num_engines)-1:0]   dbg_dptr_o,
  output logic [ptr_width(p_num_engines)-1:0]   dbg_cptr_o
);

  localparam int unsigned     PTR_W = ptr_width(p_num_engines);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(p_num_engines - 1);

  logic [PTR_W-1:0]         dptr_q, dptr_d;
  logic [PTR_W-1:0]         cptr_q, cptr_d;
  logic [p_num_engines-1:0] load;
  logic [p_num_engines-1:0] unload;
  logic [p_num_engines-1:0] busy;
  logic [p_num_engines-1:0] done;
  logic [p_width-1:0]       result    [p_num_engines];
  eng_state_e               eng_state [p_num_engines];
  logic                     head_idle;
  logic                     head_done;
  logic [p_width-1:0]       head_result;
  logic                     accept;
  logic                     deliver;

  for (genvar i = 0; i < p_num_engines; i++) begin : g_eng
    gcd_unit_multi_engine_engine #(
      .p_width(p_width)
    ) u_engine (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load[i]),
      .a_i     (istream_msg_i[2*p_width-1:p_width]),
      .b_i     (istream_msg_i[p_width-1:0]),
      .unload_i(unload[i]),
      .busy_o  (busy[i]),
      .done_o  (done[i]),
      .result_o(result[i]),
      .state_o (eng_state[i])
    );
    assign dbg_eng_state_o[2*i +: 2] = eng_state[i];
  end

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Compare-based selection keeps non-power-of-two engine counts in range.
  always_comb begin
    head_idle   = 1'b0;
    head_done   = 1'b0;
    head_result = '0;
    for (int i = 0; i < p_num_engines; i++) begin
      if (dptr_q == PTR_W'(i)) head_idle = !busy[i];
      if (cptr_q == PTR_W'(i)) begin
        head_done   = done[i];
        head_result = result[i];
      end
    end
  end

  assign istream_rdy_o = rst & head_idle;
  assign accept        = istream_val_i & istream_rdy_o;
  assign ostream_val_o = head_done;
  assign ostream_msg_o = head_done ? head_result : '0;
  assign deliver       = head_done & ostream_rdy_i;

  always_comb begin
    load   = '0;
    unload = '0;
    for (int i = 0; i < p_num_engines; i++) begin
      load[i]   = accept  && (dptr_q == PTR_W'(i));
      unload[i] = deliver && (cptr_q == PTR_W'(i));
    end
  end

  always_comb begin
    dptr_d = accept  ? next_ptr(dptr_q) : dptr_q;
    cptr_d = deliver ? next_ptr(cptr_q) : cptr_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dptr_q <= '0;
      cptr_q <= '0;
    end else begin
      dptr_q <= dptr_d;
      cptr_q <= cptr_d;
    end
  end

  assign dbg_dptr_o = dptr_q;
  assign dbg_cptr_o = cptr_q;

endmodule

// File: tb/tb_gcd_unit_multi_engine.sv
// Bench for gcd_unit_multi_engine: four 32-bit instances with 1..4 engines, vector
// tables, hand-written corner sequences and random traffic against a modulo-Euclid model.
module tb_gcd_unit_multi_engine;
  import gcd_unit_multi_engine_pkg::*;

  localparam int W   = 32;
  localparam int NI  = 4;
  localparam int TMO = 2000;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_val  [NI];
  logic           in_rdy  [NI];
  logic [2*W-1:0] in_msg  [NI];
  logic           out_val [NI];
  logic           out_rdy [NI];
  logic [W-1:0]   out_msg [NI];

  int n_tests = 0;
  int n_fail  = 0;

  vec_t order_v[$];
  vec_t width_v[$];
  vec_t reset_v[$];

  always #5 clk = ~clk;

  // Instance k carries k+1 engines.
  for (genvar k = 0; k < NI; k++) begin : g_dut
    logic [2*(k+1)-1:0]        dbg_state;
    logic [ptr_width(k+1)-1:0] dbg_dptr;
    logic [ptr_width(k+1)-1:0] dbg_cptr;
    gcd_unit_multi_engine #(
      .p_width(W),
      .p_num_engines(k + 1)
    ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .istream_val_i  (in_val[k]),
      .istream_rdy_o  (in_rdy[k]),
      .istream_msg_i  (in_msg[k]),
      .ostream_val_o  (out_val[k]),
      .ostream_rdy_i  (out_rdy[k]),
      .ostream_msg_o  (out_msg[k]),
      .dbg_eng_state_o(dbg_state),
      .dbg_dptr_o     (dbg_dptr),
      .dbg_cptr_o     (dbg_cptr)
    );
  end

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] t;
    x = a;
    y = b;
    while (y != '0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out after %0d cycles", name, TMO);
  endtask

  // Called on a negedge; returns on the negedge after the accepting posedge.
  task automatic send(input int k, input logic [W-1:0] a, input logic [W-1:0] b, input int dly);
    gcd_imsg_t m;
    int        t;
    t = 0;
    repeat ($urandom_range(0, dly)) @(negedge clk);
    m         = mk_imsg(W, gcd_word_t'(a), gcd_word_t'(b));
    in_msg[k] = m[2*W-1:0];
    in_val[k] = 1'b1;
    while (!in_rdy[k] && t < TMO) begin
      @(negedge clk);
      t++;
    end
    if (t >= TMO) timeout_fail($sformatf("send_k%0d", k));
    @(negedge clk);
    in_val[k] = 1'b0;
  endtask

  task automatic recv(input int k, input int dly, output logic [W-1:0] got);
    int t;
    t = 0;
    repeat ($urandom_range(0, dly)) @(negedge clk);
    out_rdy[k] = 1'b1;
    while (!out_val[k] && t < TMO) begin
      @(negedge clk);
      t++;
    end
    if (t >= TMO) begin
      timeout_fail($sformatf("recv_k%0d", k));
      got = '1;
    end else begin
      got = out_msg[k];
    end
    @(negedge clk);
    out_rdy[k] = 1'b0;
  endtask

  task automatic run_vectors(input int k, input vec_t v[$], input string tag);
    fork
      begin
        foreach (v[i]) send(k, v[i].a, v[i].b, 0);
      end
      begin
        logic [W-1:0] got;
        foreach (v[i]) begin
          recv(k, 0, got);
          check($sformatf("%s_%0d", tag, i), got, v[i].exp);
        end
      end
    join
  endtask

  task automatic run_random(input int k, input int count);
    logic [W-1:0] exp_q[$];
    fork
      begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < count; i++) begin
          a = W'($urandom_range(0, 300));
          b = W'($urandom_range(0, 300));
          if ($urandom_range(0, 9) == 0) b = '0;
          if ($urandom_range(0, 9) == 0) a = '0;
          exp_q.push_back(ref_gcd(a, b));
          send(k, a, b, 3);
        end
      end
      begin
        logic [W-1:0] got;
        for (int i = 0; i < count; i++) begin
          recv(k, 3, got);
          if (exp_q.size() == 0) begin
            check($sformatf("rand_k%0d_%0d_unexpected", k, i), got, '1 ^ got);
          end else begin
            check($sformatf("rand_k%0d_%0d", k, i), got, exp_q.pop_front());
          end
        end
      end
    join
  endtask

  // Stalled responses must hold val and msg until accepted.
  logic         stall_q   [NI];
  logic [W-1:0] stall_msg [NI];
  always @(negedge clk) begin
    #1;
    for (int k = 0; k < NI; k++) begin
      if (!rst) begin
        stall_q[k] = 1'b0;
      end else begin
        if (stall_q[k]) begin
          n_tests++;
          if (!(out_val[k] === 1'b1 && out_msg[k] === stall_msg[k])) begin
            n_fail++;
            $display("FAIL hold_k%0d: got val=%0b msg=0x%0h, expected val=1 msg=0x%0h",
                     k, out_val[k], out_msg[k], stall_msg[k]);
          end
        end
        stall_q[k]   = out_val[k] && !out_rdy[k];
        stall_msg[k] = out_msg[k];
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] got;
    int           acc;
    int           seen;

    order_v.push_back('{32'd250, 32'd190, 32'd10});
    order_v.push_back('{32'd40,  32'd40,  32'd40});
    order_v.push_back('{32'd0,   32'd0,   32'd0});
    order_v.push_back('{32'd5,   32'd250, 32'd5});
    order_v.push_back('{32'd3,   32'd9,   32'd3});
    order_v.push_back('{32'd27,  32'd15,  32'd3});
    order_v.push_back('{32'd21,  32'd49,  32'd7});
    order_v.push_back('{32'd19,  32'd27,  32'd1});

    width_v.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    width_v.push_back('{32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h7FFF_FFFF});
    width_v.push_back('{32'd0,         32'd7,         32'd7});
    width_v.push_back('{32'd7,         32'd0,         32'd7});
    width_v.push_back('{32'h8000_0000, 32'h4000_0000, 32'h4000_0000});
    width_v.push_back('{32'd0,         32'd0,         32'd0});

    reset_v.push_back('{32'd6, 32'd4, 32'd2});

    for (int k = 0; k < NI; k++) begin
      in_val[k]  = 1'b0;
      in_msg[k]  = '0;
      out_rdy[k] = 1'b0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("rst_rdy_k%0d", k), W'(in_rdy[k]), '0);
      check($sformatf("rst_val_k%0d", k), W'(out_val[k]), '0);
      check($sformatf("rst_msg_k%0d", k), out_msg[k], '0);
    end
    rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NI; k++) check($sformatf("post_rst_rdy_k%0d", k), W'(in_rdy[k]), 32'd1);

    // Single engine: gcd(x,0) latency, no same-cycle reload, basic result
    send(0, 32'd9, 32'd0, 0);
    check("lat_val_c1", W'(out_val[0]), '0);
    @(negedge clk);
    check("lat_val_c2", W'(out_val[0]), 32'd1);
    check("lat_msg_c2", out_msg[0], 32'd9);
    check("single_full_rdy", W'(in_rdy[0]), '0);
    recv(0, 0, got);
    check("lat_recv", got, 32'd9);
    check("single_freed_rdy", W'(in_rdy[0]), 32'd1);
    send(0, 32'd15, 32'd5, 0);
    check("basic_val_c1", W'(out_val[0]), '0);
    @(negedge clk);
    check("basic_val_c2", W'(out_val[0]), '0);
    recv(0, 0, got);
    check("basic_recv", got, 32'd5);

    // Ordering across four engines
    run_vectors(3, order_v, "order");

    // Full and backpressure on three engines
    out_rdy[2] = 1'b0;
    begin
      gcd_imsg_t m;
      m = mk_imsg(W, gcd_word_t'(12), gcd_word_t'(8));
      in_msg[2] = m[2*W-1:0];
    end
    in_val[2] = 1'b1;
    acc = 0;
    for (int c = 0; c < 30; c++) begin
      if (in_rdy[2]) acc++;
      @(negedge clk);
    end
    in_val[2] = 1'b0;
    check("full_accepted", W'(acc), 32'd3);
    check("full_rdy", W'(in_rdy[2]), '0);
    check("full_hold_val", W'(out_val[2]), 32'd1);
    check("full_hold_msg", out_msg[2], 32'd4);
    fork
      begin
        send(2, 32'd12, 32'd8, 0);
        send(2, 32'd12, 32'd8, 0);
      end
      begin
        for (int i = 0; i < 5; i++) begin
          recv(2, 0, got);
          check($sformatf("full_recv_%0d", i), got, 32'd4);
        end
      end
    join

    // Width boundaries on two engines
    run_vectors(1, width_v, "width");

    // Reset during calculation
    send(3, 32'd1000, 32'd3, 0);
    repeat (5) @(negedge clk);
    check("mid_calc_val", W'(out_val[3]), '0);
    rst = 1'b0;
    #1;
    check("in_rst_rdy", W'(in_rdy[3]), '0);
    check("in_rst_val", W'(out_val[3]), '0);
    check("in_rst_msg", out_msg[3], '0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rel_rdy", W'(in_rdy[3]), 32'd1);
    check("rel_val", W'(out_val[3]), '0);
    check("rel_states", W'(g_dut[3].dbg_state), '0);
    run_vectors(3, reset_v, "after_rst");
    out_rdy[3] = 1'b1;
    seen = 0;
    for (int c = 0; c < 400; c++) begin
      if (out_val[3]) seen++;
      @(negedge clk);
    end
    out_rdy[3] = 1'b0;
    check("no_stale", W'(seen), '0);

    // Random traffic with delays on 1, 3 and 4 engines
    run_random(0, 40);
    run_random(2, 40);
    run_random(3, 40);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gcd_unit_multi_engine.md
Name: gcd_unit_multi_engine

Overview:
Width-parametrised, multi-engine successor to the single-engine GCD unit. Streams in operand pairs {a,b} and streams out gcd(a,b). Requests are dispatched round-robin across p_num_engines subtractive-Euclid engines, and results are collected in the same round-robin order, so responses always leave in request order without a reorder buffer. It sits in the hw/gcd accelerator area behind standard StreamIntf val/rdy streams.

Parameters:
p_width, 16, operand/result bit width (>=2)
p_num_engines, 4, number of parallel GCD engines (>=1, need not be power of two)

Ports:
clk  input  1  clock, all state on posedge
rst  input  1  asynchronous active-low reset (rst==0 resets immediately; released synchronously by testbench)
istream  StreamIntf (dut side)  msg 2*p_width  request; msg[2*p_width-1:p_width]=a, msg[p_width-1:0]=b; val in, rdy out
ostream  StreamIntf (dut side)  msg p_width  response gcd(a,b); val out, rdy in

Behaviour:
- Reset (rst==0): all engines IDLE, dispatch pointer dptr=0, collect pointer cptr=0, istream.rdy=0, ostream.val=0, ostream.msg=0; in-flight work discarded, including reset mid-calculation.
- Engine FSM states: IDLE, CALC, DONE. Registers a, b (p_width each).
  - IDLE: on load, capture a, b and go to CALC.
  - CALC, one step per cycle: if a<b swap a,b; else if b!=0 a<=a-b; else go to DONE with result=a.
  - DONE: hold result until unloaded, then go to IDLE.
- gcd(x,0)=x, gcd(0,x)=x, gcd(0,0)=0. Subtraction never underflows because a>=b is checked first. No width growth.
- istream.rdy = (engine[dptr] is IDLE), a registered-state function only. A handshake (val&&rdy) loads engine[dptr] and advances dptr, wrapping p_num_engines-1 -> 0.
- ostream.val = (engine[cptr] is DONE); ostream.msg = engine[cptr].result, and 0 when not valid. A handshake returns that engine to IDLE and advances cptr with the same wrap.
- An engine unloaded in cycle N shows IDLE in cycle N+1. It cannot be reloaded in the same cycle.
- Accept and deliver in the same cycle on different engines is allowed. With p_num_engines==1 this is the same engine, so no same-cycle accept.
- Latency: request accepted at edge N -> first CALC step at N+1. gcd(x,0): ostream.val high in cycle N+2. Each extra subtract/swap step adds 1 cycle.
- Ordering: response k always corresponds to request k, regardless of per-engine latency. A slow head engine blocks later finished engines (head-of-line, by design).
- Full: all engines busy (dptr engine not IDLE) -> istream.rdy=0.
- Empty: cptr engine not DONE -> ostream.val=0.
- ostream.rdy low: DONE engines hold results indefinitely, with no loss.
- ostream.val/msg must stay stable while val&&!rdy.
- trace() function returns a fixed-width string: per-engine state char (' ', 'C', 'D') plus the dptr/cptr digits.

Decomposition:
- Shared package hw_gcd_GcdPkg holds: the engine state enum {IDLE, CALC, DONE}, and a request-pack helper function mk_imsg(a, b) parametrised by width via a parameterised class or macro.
- One sub-module hw_gcd_GcdEngine #(p_width): load/unload ports, busy/done status, result out. The top holds the pointers and the mux/demux.
- The pointer width is $clog2(p_num_engines), with a minimum of 1 bit.

Test Plan:
- Basic (p_num_engines=1, p_width=16): send {15,5} -> recv 5. ostream.val must not rise before 2 cycles after accept.
- Ordering (p_num_engines=4): send {250,190},{40,40},{0,0},{5,250},{3,9},{27,15},{21,49},{19,27} back-to-back -> recv 10,40,0,5,3,3,7,1 in that order. {40,40} finishes before {250,190} but is delivered second.
- Full/backpressure (p_num_engines=3): hold ostream.rdy=0, send 5 requests {12,8} -> exactly 3 accepted, istream.rdy=0 afterward. Release rdy -> recv 4,4,4,4,4 with one accept per freed engine.
- Width/boundary (p_width=32, p_num_engines=2): send {0xFFFFFFFF,1},{0,7},{7,0},{0x80000000,0x40000000} -> recv 1,7,7,0x40000000.
- Reset mid-operation: accept {1000,3}, drop rst to 0 during CALC, release -> ostream.val=0 and istream.rdy=1 next cycle. Send {6,4} -> recv 2 only; the stale result is never emitted.
- Random with delays: 40 random pairs against the software gcd model, istream delay 3 and ostream delay 3, for p_num_engines in {1,3,4} -> all match in order.
